// File: rtl/clk_div_prog_if.sv
// clk_div_prog_if -- control/status bundle for the programmable clock divider.
//
// Signals:
//   en      count enable (low freezes the divider)
//   div_i   requested divisor, W bits
//   load_i  one-cycle strobe capturing div_i
//   clk_o   divided clock
//   tick_o  one-cycle pulse at each period wrap
//   upd_o   one-cycle pulse when a pending divisor becomes active
//   err_o   one-cycle pulse when a load is rejected (div_i < 2)
//   div_o   currently active divisor
//
// Modports:
//   master  the controller side (drives en/div_i/load_i)
//   slave   the divider side (drives the outputs)
//
// W must match the W of the clk_div_prog instance it connects to.

interface clk_div_prog_if #(
  parameter int unsigned W = 8
) ();

  logic         en;
  logic [W-1:0] div_i;
  logic         load_i;
  logic         clk_o;
  logic         tick_o;
  logic         upd_o;
  logic         err_o;
  logic [W-1:0] div_o;

  modport master (
    output en,
    output div_i,
    output load_i,
    input  clk_o,
    input  tick_o,
    input  upd_o,
    input  err_o,
    input  div_o
  );

  modport slave (
    input  en,
    input  div_i,
    input  load_i,
    output clk_o,
    output tick_o,
    output upd_o,
    output err_o,
    output div_o
  );

endinterface

// File: rtl/clk_div_prog.sv
// clk_div_prog -- runtime-programmable integer clock divider.
//
// Produces a registered divided clock (period N clk cycles, low phase first) and a
// one-cycle tick at every period wrap. A new divisor is loaded with a strobe, held
// pending, and becomes active only at the next wrap so the output never glitches.
//
// Parameters:
//   W        divisor/counter width; legal divisors 2 .. 2^W-1
//   DEF_DIV  active divisor after reset (2 .. 2^W-1)
//
// Ports:
//   clk      source clock (rising edge, plus falling edge for the optional stage)
//   rstn     synchronous active-low reset
//   bus      clk_div_prog_if.slave: en, div_i, load_i in; clk_o, tick_o, upd_o,
//            err_o, div_o out
//
// Build option:
//   CLKDIV_ODD_DUTY50_EN  when defined, a falling-edge flop stretches the high phase
//                         by half a clk cycle for odd N, giving exact 50 % duty.
//                         Even N is unaffected. Undefined: pure rising-edge design,
//                         odd N has duty floor(N/2)/N.

module clk_div_prog #(
  parameter int unsigned W       = 8,
  parameter int unsigned DEF_DIV = 4
) (
  input logic          clk,
  input logic          rstn,
  clk_div_prog_if.slave bus
);

  localparam logic [W-1:0] DefDiv = W'(DEF_DIV);
  localparam logic [W-1:0] One    = W'(1);
  localparam logic [W-1:0] MinDiv = W'(2);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] div_q, div_d;
  logic [W-1:0] pend_q, pend_d;
  logic         pend_v_q, pend_v_d;
  logic         clk_q, clk_d;
  logic         tick_q, tick_d;
  logic         upd_q, upd_d;
  logic         err_q, err_d;

  logic         wrap;
  logic         load_ok;
  logic         load_bad;
  logic         apply;
  logic [W:0]   low_len;

  always_comb begin
    // >= rather than == so a corrupted counter still recovers at the next edge.
    wrap     = bus.en && (cnt_q >= (div_q - One));
    load_ok  = bus.load_i && (bus.div_i >= MinDiv);
    load_bad = bus.load_i && (bus.div_i < MinDiv);
    // A valid load on the wrap edge replaces the pending value instead of applying it.
    apply    = wrap && pend_v_q && !load_ok;
    // Low phase is ceil(N/2); one extra bit so N = 2^W-1 does not overflow.
    low_len  = ({1'b0, div_q} + (W+1)'(1)) >> 1;

    cnt_d    = cnt_q;
    clk_d    = clk_q;
    div_d    = div_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    tick_d   = wrap;
    upd_d    = apply;
    err_d    = load_bad;

    if (bus.en) begin
      cnt_d = wrap ? '0 : cnt_q + One;
      // After a wrap cnt_d is 0 and low_len >= 1, so the period always opens low.
      clk_d = ({1'b0, cnt_d} >= low_len);
    end

    if (apply) begin
      div_d    = pend_q;
      pend_v_d = 1'b0;
    end

    if (load_ok) begin
      pend_d   = bus.div_i;
      pend_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q    <= '0;
      div_q    <= DefDiv;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      clk_q    <= 1'b0;
      tick_q   <= 1'b0;
      upd_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      clk_q    <= clk_d;
      tick_q   <= tick_d;
      upd_q    <= upd_d;
      err_q    <= err_d;
    end
  end

`ifdef CLKDIV_ODD_DUTY50_EN
  // Half-cycle extension: follows clk_q on the falling edge for odd N only, so the
  // OR keeps clk_o high for an extra half clk cycle after clk_q drops.
  logic q_n;

  always_ff @(negedge clk) begin
    if (!rstn) begin
      q_n <= 1'b0;
    end else begin
      q_n <= clk_q & div_q[0];
    end
  end

  assign bus.clk_o = clk_q | q_n;
`else
  assign bus.clk_o = clk_q;
`endif

  assign bus.tick_o = tick_q;
  assign bus.upd_o  = upd_q;
  assign bus.err_o  = err_q;
  assign bus.div_o  = div_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog -- self-checking bench for clk_div_prog.
// The reference model keeps the active divisor, the pending load and a queue of the
// clk_o levels still to come in the current period; an empty queue means the next
// enabled edge is a period wrap.

module tb_clk_div_prog;

  localparam int unsigned W       = 8;
  localparam int unsigned DEF_DIV = 4;

  typedef logic [W+3:0] vec_t;

  logic clk = 1'b1;
  logic rstn;

  int tests_run    = 0;
  int tests_failed = 0;

  clk_div_prog_if #(.W(W)) bus ();

  clk_div_prog #(
    .W      (W),
    .DEF_DIV(DEF_DIV)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_n;
  int m_pend;
  bit m_pend_v;
  int m_q[$];
  bit e_clk, e_tick, e_upd, e_err, e_qn;

  // Levels for positions 1..N-1 of a period: rest of the low phase, then the high phase.
  function automatic void refill();
    m_q.delete();
    for (int p = 1; p < (m_n + 1) / 2; p++) m_q.push_back(0);
    for (int p = 0; p < m_n / 2; p++) m_q.push_back(1);
  endfunction

  function automatic logic exp_clk_o();
`ifdef CLKDIV_ODD_DUTY50_EN
    return e_clk | e_qn;
`else
    return e_clk;
`endif
  endfunction

  function automatic vec_t exp_vec();
    return {exp_clk_o(), e_tick, e_upd, e_err, W'(m_n)};
  endfunction

  function automatic vec_t obs_vec();
    return {bus.clk_o, bus.tick_o, bus.upd_o, bus.err_o, bus.div_o};
  endfunction

  // One clk cycle: sample the driven inputs, advance the model at the edge, settle.
  task automatic step();
    bit en_s, ld_s, valid;
    int dv_s;
    en_s  = bus.en;
    ld_s  = bus.load_i;
    dv_s  = int'(bus.div_i);
    // Falling-edge stretch flop as seen just after the coming rising edge.
    e_qn  = rstn && e_clk && (m_n % 2 == 1);
    @(posedge clk);
    if (!rstn) begin
      m_n = DEF_DIV; m_pend_v = 0; m_pend = 0;
      e_clk = 0; e_tick = 0; e_upd = 0; e_err = 0;
      refill();
    end else begin
      valid  = ld_s && dv_s >= 2;
      e_err  = ld_s && dv_s < 2;
      e_tick = 0;
      e_upd  = 0;
      if (en_s) begin
        if (m_q.size() > 0) begin
          e_clk = m_q.pop_front() != 0;
        end else begin
          if (m_pend_v && !valid) begin
            m_n = m_pend; m_pend_v = 0; e_upd = 1;
          end
          e_clk = 0; e_tick = 1;
          refill();
        end
      end
      if (valid) begin
        m_pend = dv_s; m_pend_v = 1;
      end
    end
    #1;
  endtask

  function automatic int model_cnt();
    return m_n - 1 - m_q.size();
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 1'b0; bus.en = 1'b1; bus.load_i = 1'b1; bus.div_i = W'(7);
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (obs_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL reset cyc%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    tests_run++;
    if (bus.div_o !== W'(DEF_DIV)) begin
      tests_failed++;
      $display("FAIL reset_div: got %0d want %0d", bus.div_o, DEF_DIV);
    end
    bus.load_i = 1'b0; rstn = 1'b1;
  endtask

  task automatic test_basic_n4();
    int ticks, highs;
    ticks = 0; highs = 0;
    bus.en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      ticks += int'(bus.tick_o);
      highs += int'(bus.clk_o);
      tests_run++;
      if (obs_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL basic_n4 cyc%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    tests_run++;
    if (ticks != 3 || highs != 6) begin
      tests_failed++;
      $display("FAIL basic_n4_counts: got ticks=%0d highs=%0d want ticks=3 highs=6",
               ticks, highs);
    end
  endtask

  task automatic test_load_apply();
    int guard, upds;
    upds = 0;
    for (guard = 0; guard < 64 && model_cnt() != 1; guard++) step();
    tests_run++;
    if (guard >= 64) begin
      tests_failed++;
      $display("FAIL load_align: timeout got cnt=%0d want 1", model_cnt());
    end
    bus.load_i = 1'b1; bus.div_i = W'(6);
    step();
    bus.load_i = 1'b0;
    for (int i = 0; i < 24; i++) begin
      tests_run++;
      if (obs_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL load_apply cyc%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      upds += int'(bus.upd_o);
      step();
    end
    tests_run++;
    if (upds != 1 || bus.div_o !== W'(6)) begin
      tests_failed++;
      $display("FAIL load_apply_final: got upds=%0d div=%0d want upds=1 div=6",
               upds, bus.div_o);
    end
  endtask

  task automatic test_err();
    int errs;
    errs = 0;
    for (int k = 0; k < 2; k++) begin
      bus.load_i = 1'b1; bus.div_i = W'(1 - k);
      step();
      errs += int'(bus.err_o);
      bus.load_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (obs_vec() !== exp_vec()) begin
          tests_failed++;
          $display("FAIL err_load%0d cyc%0d: got %h want %h", k, i, obs_vec(), exp_vec());
        end
        step();
      end
    end
    tests_run++;
    if (errs != 2 || bus.div_o !== W'(6)) begin
      tests_failed++;
      $display("FAIL err_count: got errs=%0d div=%0d want errs=2 div=6", errs, bus.div_o);
    end
  endtask

  task automatic test_odd5();
    int guard;
    bus.load_i = 1'b1; bus.div_i = W'(5);
    step();
    bus.load_i = 1'b0;
    for (guard = 0; guard < 64 && !e_upd; guard++) step();
    tests_run++;
    if (guard >= 64) begin
      tests_failed++;
      $display("FAIL odd5_apply: timeout waiting for upd");
    end
    for (int i = 0; i < 15; i++) begin
      step();
      tests_run++;
      if (obs_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL odd5 cyc%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_enable_hold();
    int guard;
    for (guard = 0; guard < 64 && !e_clk; guard++) step();
    bus.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (obs_vec() !== exp_vec() || bus.tick_o !== 1'b0 || bus.clk_o !== 1'b1) begin
        tests_failed++;
        $display("FAIL en_hold cyc%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    bus.en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      tests_run++;
      if (obs_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL en_resume cyc%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_latest_wins_reset();
    int guard;
    for (guard = 0; guard < 64 && m_q.size() < 3; guard++) step();
    bus.load_i = 1'b1; bus.div_i = W'(8);
    step();
    bus.div_i = W'(3);
    step();
    bus.load_i = 1'b0;
    for (guard = 0; guard < 64 && !e_upd; guard++) begin
      tests_run++;
      if (obs_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL latest_wins cyc%0d: got %h want %h", guard, obs_vec(), exp_vec());
      end
      step();
    end
    tests_run++;
    if (bus.div_o !== W'(3) || bus.upd_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL latest_wins_div: got div=%0d upd=%b want div=3 upd=1",
               bus.div_o, bus.upd_o);
    end
    bus.load_i = 1'b1; bus.div_i = W'(7);
    step();
    bus.load_i = 1'b0;
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    tests_run++;
    if (bus.div_o !== W'(DEF_DIV) || bus.clk_o !== 1'b0 || bus.tick_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset: got div=%0d clk=%b tick=%b want div=%0d clk=0 tick=0",
               bus.div_o, bus.clk_o, bus.tick_o, DEF_DIV);
    end
    for (int i = 0; i < 16; i++) begin
      step();
      tests_run++;
      if (obs_vec() !== exp_vec() || bus.upd_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL after_reset cyc%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_coincident_load();
    int guard;
    for (guard = 0; guard < 64 && m_q.size() < 2; guard++) step();
    bus.load_i = 1'b1; bus.div_i = W'(9);
    step();
    bus.load_i = 1'b0;
    for (guard = 0; guard < 64 && m_q.size() != 0; guard++) step();
    // Next edge wraps: this load must replace 9 and not apply until the wrap after.
    bus.load_i = 1'b1; bus.div_i = W'(2);
    step();
    bus.load_i = 1'b0;
    tests_run++;
    if (bus.tick_o !== 1'b1 || bus.upd_o !== 1'b0 || bus.div_o !== W'(DEF_DIV)) begin
      tests_failed++;
      $display("FAIL coincident_wrap: got tick=%b upd=%b div=%0d want tick=1 upd=0 div=%0d",
               bus.tick_o, bus.upd_o, bus.div_o, DEF_DIV);
    end
    for (int i = 0; i < 12; i++) begin
      step();
      tests_run++;
      if (obs_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL coincident cyc%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    tests_run++;
    if (bus.div_o !== W'(2)) begin
      tests_failed++;
      $display("FAIL coincident_div: got %0d want 2", bus.div_o);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      bus.en     = ($urandom % 8) != 0;
      bus.load_i = ($urandom % 6) == 0;
      if ($urandom % 4 == 0)       bus.div_i = W'($urandom % 3);
      else if ($urandom % 40 == 0) bus.div_i = W'($urandom_range(13, 60));
      else                         bus.div_i = W'($urandom_range(2, 12));
      rstn = ($urandom % 300) != 0;
      step();
      tests_run++;
      if (obs_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL random cyc%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    rstn = 1'b1; bus.load_i = 1'b0; bus.en = 1'b1;
  endtask

  initial begin
    rstn       = 1'b0;
    bus.en     = 1'b0;
    bus.load_i = 1'b0;
    bus.div_i  = '0;
    m_n = DEF_DIV; m_pend = 0; m_pend_v = 0;
    e_clk = 0; e_tick = 0; e_upd = 0; e_err = 0; e_qn = 0;
    refill();

    test_reset();
    test_basic_n4();
    test_load_apply();
    test_err();
    test_odd5();
    test_enable_hold();
    test_latest_wins_reset();
    test_coincident_load();
    test_random();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
